// File: rtl/memtest_pkg.sv
// Shared types and constants for the Wishbone memory tester.
package memtest_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_WV = 2'b00;
    localparam logic [1:0] MODE_WO = 2'b01;
    localparam logic [1:0] MODE_VO = 2'b10;

    localparam logic PASS_RST = 1'b1;

endpackage

// File: rtl/memtest_checker.sv
// Read-back checker: compares each acknowledged read against the expected word,
// keeps a saturating mismatch count, the first failing address and the last read word.
module memtest_checker
    import memtest_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_rd_stb,
    input  logic [DW-1:0] i_rd_dat,
    input  logic [DW-1:0] i_exp_dat,
    input  logic [AW-1:0] i_adr,
    output logic [CW-1:0] o_err_cnt,
    output logic [AW-1:0] o_first_err_adr,
    output logic [DW-1:0] o_last_rd_dat
);

    logic [CW-1:0] r_err_cnt;
    logic [AW-1:0] r_first_err_adr;
    logic [DW-1:0] r_last_rd_dat;
    logic          w_mismatch;

    assign w_mismatch = (i_rd_dat != i_exp_dat);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt       <= '0;
            r_first_err_adr <= '0;
            r_last_rd_dat   <= '0;
        end else if (i_clr) begin
            r_err_cnt       <= '0;
            r_first_err_adr <= '0;
        end else if (i_rd_stb) begin
            r_last_rd_dat <= i_rd_dat;
            if (w_mismatch) begin
                // A zero count marks the first mismatch of the run
                if (r_err_cnt == '0)
                    r_first_err_adr <= i_adr;
                if (r_err_cnt != '1)
                    r_err_cnt <= r_err_cnt + CW'(1);
            end
        end
    end

    assign o_err_cnt       = r_err_cnt;
    assign o_first_err_adr = r_first_err_adr;
    assign o_last_rd_dat   = r_last_rd_dat;

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone master that writes seed+k over a window and reads it back for comparison.
// Optional REQ-phase ack timeout enabled by defining MEMTEST_TIMEOUT_EN.
// state    | meaning
// IDLE     | waiting for start_i
// WR_REQ   | write strobe held until ack
// WR_GAP   | one idle cycle after a write
// RD_REQ   | read strobe held until ack
// RD_GAP   | one idle cycle after a read
// DONE     | result update, one-cycle done_o
module wb_mem_tester
    import memtest_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int CW       = 16,
    parameter int ADR_STEP = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    input  logic [AW-1:0]   base_adr_i,
    input  logic [CW-1:0]   count_i,
    input  logic [DW-1:0]   seed_i,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [DW/8-1:0] wb_sel_o,
    input  logic            wb_ack_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [CW-1:0]   err_cnt_o,
    output logic [AW-1:0]   first_err_adr_o,
    output logic [DW-1:0]   last_rd_dat_o,
    output logic            timeout_o
);

    state_t        r_state;
    logic [AW-1:0] r_base;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_seed;
    logic [1:0]    r_mode;
    logic [CW-1:0] r_k;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat;
    logic          r_cyc;
    logic          r_stb;
    logic          r_we;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic          w_last;
    logic [CW-1:0] w_k_nxt;
    logic [AW-1:0] w_adr_nxt;
    logic [DW-1:0] w_dat_nxt;
    logic [DW-1:0] w_exp;
    logic          w_rd_stb;
    logic          w_clr;
    logic          w_timeout;
    logic [CW-1:0] w_err_cnt;

    assign w_last    = (r_k == r_count - CW'(1));
    assign w_k_nxt   = r_k + CW'(1);
    assign w_adr_nxt = r_base + AW'(w_k_nxt) * AW'(ADR_STEP);
    assign w_dat_nxt = r_seed + DW'(w_k_nxt);
    assign w_exp     = r_seed + DW'(r_k);
    assign w_rd_stb  = (r_state == S_RD_REQ) && wb_ack_i;
    assign w_clr     = (r_state == S_IDLE) && start_i;

`ifdef MEMTEST_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout;
    logic          w_in_req;
    logic          w_tmo_hit;

    assign w_in_req  = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
    assign w_tmo_hit = (r_tmo_cnt == '0);
    assign w_timeout = r_timeout;

    // Reloaded outside REQ so every REQ entry starts a fresh TIMEOUT-cycle window
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_tmo_cnt <= TMO_LD;
        else if (!w_in_req)
            r_tmo_cnt <= TMO_LD;
        else if (!w_tmo_hit)
            r_tmo_cnt <= r_tmo_cnt - TW'(1);
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_count <= '0;
            r_seed  <= '0;
            r_mode  <= MODE_WV;
            r_k     <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= PASS_RST;
`ifdef MEMTEST_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_base <= base_adr_i;
                        r_count <= count_i;
                        r_seed <= seed_i;
                        r_mode <= mode_i;
                        r_k <= '0;
                        r_busy <= 1'b1;
`ifdef MEMTEST_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        if (count_i == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cyc <= 1'b1;
                            r_stb <= 1'b1;
                            r_adr <= base_adr_i;
                            if (mode_i == MODE_VO) begin
                                r_we <= 1'b0;
                                r_state <= S_RD_REQ;
                            end else begin
                                r_we <= 1'b1;
                                r_dat <= seed_i;
                                r_state <= S_WR_REQ;
                            end
                        end
                    end
                end
                S_WR_REQ: begin
                    if (wb_ack_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we <= 1'b0;
                        r_state <= S_WR_GAP;
                    end
`ifdef MEMTEST_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state <= S_DONE;
                    end
`endif
                end
                S_WR_GAP: begin
                    if (w_last) begin
                        r_k <= '0;
                        if (r_mode == MODE_WO) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cyc <= 1'b1;
                            r_stb <= 1'b1;
                            r_adr <= r_base;
                            r_state <= S_RD_REQ;
                        end
                    end else begin
                        r_k <= w_k_nxt;
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_we <= 1'b1;
                        r_adr <= w_adr_nxt;
                        r_dat <= w_dat_nxt;
                        r_state <= S_WR_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (wb_ack_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_state <= S_RD_GAP;
                    end
`ifdef MEMTEST_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state <= S_DONE;
                    end
`endif
                end
                S_RD_GAP: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k <= w_k_nxt;
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_adr <= w_adr_nxt;
                        r_state <= S_RD_REQ;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_pass <= (w_err_cnt == '0) && !w_timeout;
                    r_busy <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    memtest_checker #(
        .AW(AW),
        .DW(DW),
        .CW(CW)
    ) u_checker (
        .i_clk           (wb_clk_i),
        .i_rst           (wb_rst_i),
        .i_clr           (w_clr),
        .i_rd_stb        (w_rd_stb),
        .i_rd_dat        (wb_dat_i),
        .i_exp_dat       (w_exp),
        .i_adr           (r_adr),
        .o_err_cnt       (w_err_cnt),
        .o_first_err_adr (first_err_adr_o),
        .o_last_rd_dat   (last_rd_dat_o)
    );

    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_sel_o  = '1;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign pass_o    = r_pass;
    assign err_cnt_o = w_err_cnt;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Scoreboard bench for wb_mem_tester: bus and result expectations are queued by the
// stimulus and popped by monitors on ack / done_o. Covers MEMTEST_TIMEOUT_EN when defined.
module tb_wb_mem_tester;
    import memtest_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } bus_t;

    typedef struct {
        logic          pass;
        logic [CW-1:0] err;
        logic [AW-1:0] fadr;
        logic [DW-1:0] last;
        logic          tmo;
        int            lat;
    } res_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [AW-1:0]   base = '0;
    logic [CW-1:0]   count = '0;
    logic [DW-1:0]   seed = '0;
    logic [AW-1:0]   wb_adr;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_cyc, wb_stb, wb_we, wb_ack;
    logic [DW/8-1:0] wb_sel;
    logic            busy, done, pass, tmo;
    logic [CW-1:0]   err_cnt;
    logic [AW-1:0]   first_err_adr;
    logic [DW-1:0]   last_rd_dat;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_cnt = 0;
    int t_start = 0;
    int done_cnt = 0;
    int delay = 0;
    bit ack_en = 1'b1;
    bit corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_adr = '0;
    bit stab_en = 1'b0;
    bit stb_seen = 1'b0;
    int wcnt = 0;
    logic [DW-1:0] mem [0:255];

    bus_t bus_q[$];
    res_t res_q[$];

    wb_mem_tester #(
        .AW(AW), .DW(DW), .CW(CW), .ADR_STEP(1), .TIMEOUT(16)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .start_i         (start),
        .mode_i          (mode),
        .base_adr_i      (base),
        .count_i         (count),
        .seed_i          (seed),
        .wb_adr_o        (wb_adr),
        .wb_dat_o        (wb_dat_o),
        .wb_dat_i        (wb_dat_i),
        .wb_cyc_o        (wb_cyc),
        .wb_stb_o        (wb_stb),
        .wb_we_o         (wb_we),
        .wb_sel_o        (wb_sel),
        .wb_ack_i        (wb_ack),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_cnt_o       (err_cnt),
        .first_err_adr_o (first_err_adr),
        .last_rd_dat_o   (last_rd_dat),
        .timeout_o       (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Slave model: optional wait states, optional read corruption
    assign wb_ack = wb_cyc && wb_stb && ack_en && (wcnt == delay);
    assign wb_dat_i = (corrupt_en && wb_adr == corrupt_adr) ? '0 : mem[wb_adr[7:0]];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!(wb_cyc && wb_stb) || wb_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (wb_ack && wb_we) mem[wb_adr[7:0]] <= wb_dat_o;
    end

    // Bus monitor
    always @(negedge clk) begin
        bus_t e;
        if (wb_stb) stb_seen <= 1'b1;
        if (!rst && wb_cyc && wb_stb && wb_ack) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 1, 0);
            end else begin
                e = bus_q.pop_front();
                check("bus_we", wb_we, e.we);
                check("bus_adr", wb_adr, e.adr);
                if (e.we) check("bus_wdat", wb_dat_o, e.dat);
                check("bus_sel", wb_sel, 4'hF);
            end
        end
    end

    // Result monitor
    always @(negedge clk) begin
        res_t r;
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (res_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                r = res_q.pop_front();
                check("pass", pass, r.pass);
                check("err_cnt", err_cnt, r.err);
                check("first_err_adr", first_err_adr, r.fadr);
                check("last_rd_dat", last_rd_dat, r.last);
                check("timeout", tmo, r.tmo);
                check("busy_at_done", busy, 0);
                if (r.lat != 0) check("latency", cyc_cnt - t_start, r.lat);
            end
        end
    end

    // Stability / idle-gap monitor for wait-state runs
    logic          p_act = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [AW-1:0] p_adr = '0;
    logic [DW-1:0] p_dat = '0;
    int            gap_state = 0;
    always @(negedge clk) begin
        if (stab_en && !rst) begin
            if (p_act && !p_ack && wb_cyc && wb_stb) begin
                check("stable_adr", wb_adr, p_adr);
                check("stable_we", wb_we, p_we);
                if (wb_we) check("stable_dat", wb_dat_o, p_dat);
            end
            if (gap_state == 1) begin
                check("gap_idle", wb_stb, 0);
                gap_state <= (bus_q.size() != 0) ? 2 : 0;
            end else if (gap_state == 2) begin
                check("gap_len", wb_stb, 1);
                gap_state <= 0;
            end
            if (wb_cyc && wb_stb && wb_ack) gap_state <= 1;
        end
        p_act <= wb_cyc && wb_stb;
        p_ack <= wb_ack;
        p_adr <= wb_adr;
        p_dat <= wb_dat_o;
        p_we  <= wb_we;
    end

    task automatic push_bus(input logic [1:0] m, input logic [AW-1:0] b,
                            input int n, input logic [DW-1:0] s);
        bus_t e;
        if (m != MODE_VO)
            for (int k = 0; k < n; k++) begin
                e.we = 1'b1; e.adr = b + AW'(k); e.dat = s + DW'(k);
                bus_q.push_back(e);
            end
        if (m != MODE_WO)
            for (int k = 0; k < n; k++) begin
                e.we = 1'b0; e.adr = b + AW'(k); e.dat = '0;
                bus_q.push_back(e);
            end
    endtask

    task automatic push_res(input logic p, input logic [CW-1:0] e, input logic [AW-1:0] f,
                            input logic [DW-1:0] l, input logic t, input int lat);
        res_t r;
        r.pass = p; r.err = e; r.fadr = f; r.last = l; r.tmo = t; r.lat = lat;
        res_q.push_back(r);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [AW-1:0] b,
                            input logic [CW-1:0] n, input logic [DW-1:0] s);
        @(negedge clk);
        mode = m; base = b; count = n; seed = s;
        start = 1'b1;
        t_start = cyc_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  d0;
        bit  got;
        d0 = done_cnt;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", got, 1);
        @(negedge clk);
        check("bus_left", bus_q.size(), 0);
        check("res_left", res_q.size(), 0);
    endtask

    task automatic run(input logic [1:0] m, input logic [AW-1:0] b, input logic [CW-1:0] n,
                       input logic [DW-1:0] s, input logic p, input logic [CW-1:0] e,
                       input logic [AW-1:0] f, input logic [DW-1:0] l, input int lat);
        push_bus(m, b, int'(n), s);
        push_res(p, e, f, l, 1'b0, lat);
        do_start(m, b, n, s);
        wait_done(400);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 1);
        check("rst_err", err_cnt, 0);
        check("rst_last", last_rd_dat, 0);
        check("rst_tmo", tmo, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(2'b00, 32'h1000, 16'd4, 32'hA5A50000, 1, 0, 0, 32'hA5A50003, 18);

        corrupt_en = 1'b1; corrupt_adr = 32'h1002;
        run(2'b00, 32'h1000, 16'd4, 32'hA5A50000, 0, 1, 32'h1002, 32'hA5A50003, 18);
        corrupt_en = 1'b0;

        stb_seen = 1'b0;
        @(negedge clk);
        stb_seen = 1'b0;
        run(2'b00, 32'h5000, 16'd0, 32'h1, 1, 0, 0, 32'hA5A50003, 2);
        check("cnt0_no_stb", stb_seen, 0);

        run(2'b10, 32'h1000, 16'd4, 32'hA5A50001, 0, 4, 32'h1000, 32'hA5A50003, 10);
        run(2'b10, 32'h1000, 16'd4, 32'hA5A50000, 1, 0, 0, 32'hA5A50003, 10);
        run(2'b01, 32'hFFFFFFFF, 16'd2, 32'hFFFFFFFF, 1, 0, 0, 32'hA5A50003, 6);
        run(2'b11, 32'hFFFFFFFF, 16'd2, 32'hFFFFFFFF, 1, 0, 0, 32'h00000000, 10);

        // Wait-state run with a start pulse while busy
        delay = 5; stab_en = 1'b1;
        push_bus(2'b00, 32'h20, 2, 32'h10);
        push_res(1, 0, 0, 32'h11, 1'b0, 0);
        do_start(2'b00, 32'h20, 16'd2, 32'h10);
        repeat (3) @(negedge clk);
        mode = 2'b01; base = 32'h80; count = 16'd3; seed = 32'h99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        stab_en = 1'b0;

        // Reset during the third write request
        push_bus(2'b01, 32'h40, 2, 32'h100);
        do_start(2'b00, 32'h40, 16'd4, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wb_cyc && wb_stb && wb_we && wb_adr == 32'h42) begin
                found = 1'b1;
                break;
            end
        end
        check("third_write_seen", found, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_cyc", wb_cyc, 0);
        check("mid_rst_stb", wb_stb, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_pass", pass, 1);
        check("mid_rst_bus_left", bus_q.size(), 0);
        delay = 0;
        run(2'b01, 32'h60, 16'd2, 32'h7, 1, 0, 0, 32'h0, 6);

`ifdef MEMTEST_TIMEOUT_EN
        ack_en = 1'b0;
        push_res(0, 0, 0, 32'h0, 1'b1, 18);
        do_start(2'b00, 32'h70, 16'd2, 32'h0);
        wait_done(100);
        ack_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
